unloader_mem_reader: RTL and testbench

- Memory-side stage feeding data_unloader: serves its byte read requests (read_en/read_addr -> read_data) from a 16-bit-wide memory port with a request/acknowledge handshake.
- Sits entirely in the clk_memory domain, between data_unloader and the memory controller (SDRAM/PSRAM arbiter).
- Returns each byte with a read_valid strobe.
- Keeps an optional one-word cache so sequential byte reads in the same 16-bit word need no second memory access.

---
 rtl/unloader_mem_reader.sv | 157 +++++++++++++++
 tb/tb_unloader_mem_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/unloader_mem_reader.sv
// Byte reader for data_unloader: turns byte reads into 16-bit memory word requests with timeout.
// Define UNLOADER_MEM_READER_WORD_CACHE_EN to keep the last fetched word for same-word hits.
module unloader_mem_reader #(
  parameter int ADDR_WIDTH      = 28,
  parameter bit BIG_ENDIAN_WORD = 1'b0,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk_memory,
  input  logic                  reset_n,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [7:0]            read_data,
  output logic                  read_valid,
  output logic                  busy,
  input  logic                  invalidate,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  input  logic [15:0]           mem_rd_data,
  input  logic                  mem_ack,
  output logic                  timeout,
  output logic                  overrun,
  output logic                  state_dbg
);

  // Memory handshake: mem_rd is a level held with a stable mem_addr until the
  // one-cycle mem_ack, which also qualifies mem_rd_data; acks outside REQ are ignored.
  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic                  mem_rd_d;
  logic [ADDR_WIDTH-2:0] mem_addr_d;
  logic [7:0]            read_data_d;
  logic                  read_valid_d, timeout_d, overrun_d;
  logic                  hit, fill;
  logic [15:0]           hit_word;
  logic                  req_sel;

  assign req_sel   = read_addr[0] ^ BIG_ENDIAN_WORD;
  assign busy      = (state_q == REQ);
  assign state_dbg = state_q;
  assign fill      = (state_q == REQ) && mem_ack;

`ifdef UNLOADER_MEM_READER_WORD_CACHE_EN
  logic                  cache_valid_q, cache_valid_d;
  logic [ADDR_WIDTH-2:0] cache_tag_q, cache_tag_d;
  logic [15:0]           cache_word_q, cache_word_d;

  // A coincident invalidate forces the lookup to miss.
  assign hit      = cache_valid_q && (cache_tag_q == read_addr[ADDR_WIDTH-1:1]) && !invalidate;
  assign hit_word = cache_word_q;

  always_comb begin
    cache_valid_d = cache_valid_q & ~invalidate;
    cache_tag_d   = cache_tag_q;
    cache_word_d  = cache_word_q;
    if (fill) begin
      cache_valid_d = 1'b1;
      cache_tag_d   = mem_addr;
      cache_word_d  = mem_rd_data;
    end
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_word_q  <= cache_word_d;
    end
  end
`else
  logic unused_invalidate;
  assign unused_invalidate = invalidate;
  assign hit      = 1'b0;
  assign hit_word = 16'h0000;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    mem_rd_d     = mem_rd;
    mem_addr_d   = mem_addr;
    read_data_d  = read_data;
    read_valid_d = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_en) begin
          if (hit) begin
            read_valid_d = 1'b1;
            read_data_d  = req_sel ? hit_word[15:8] : hit_word[7:0];
          end else begin
            state_d    = REQ;
            mem_rd_d   = 1'b1;
            mem_addr_d = read_addr[ADDR_WIDTH-1:1];
            sel_d      = req_sel;
            cnt_d      = '0;
          end
        end
      end
      REQ: begin
        overrun_d = read_en;
        if (mem_ack) begin
          state_d      = IDLE;
          mem_rd_d     = 1'b0;
          read_valid_d = 1'b1;
          read_data_d  = sel_q ? mem_rd_data[15:8] : mem_rd_data[7:0];
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // Counter starts at 0 on the mem_rd rise, so mem_rd stays high TIMEOUT_CYCLES cycles.
          state_d      = IDLE;
          mem_rd_d     = 1'b0;
          read_valid_d = 1'b1;
          read_data_d  = 8'hFF;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      read_data  <= 8'h00;
      read_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      read_data  <= read_data_d;
      read_valid <= read_valid_d;
      timeout    <= timeout_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_unloader_mem_reader.sv
// Bench for unloader_mem_reader: little- and big-endian instances share one stimulus stream
// and are checked against a transaction-level model of the read/cache/timeout rules.
module tb_unloader_mem_reader;

`ifdef UNLOADER_MEM_READER_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_en = 1'b0;
  logic [27:0] read_addr = '0;
  logic        invalidate = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rd_data = '0;

  logic [7:0]  rd_le, rd_be;
  logic        rv_le, rv_be, busy_le, busy_be, mr_le, mr_be;
  logic [26:0] ma_le, ma_be;
  logic        to_le, to_be, ov_le, ov_be, dbg_le, dbg_be;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cached word and the held read_data of each instance.
  bit          m_valid = 1'b0;
  logic [26:0] m_tag = '0;
  logic [15:0] m_word = '0;
  logic [7:0]  exp_le = 8'h00, exp_be = 8'h00;

  always #5 clk = ~clk;

  unloader_mem_reader #(.ADDR_WIDTH(28), .BIG_ENDIAN_WORD(1'b0), .TIMEOUT_CYCLES(TMO)) u_le (
    .clk_memory(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_le), .read_valid(rv_le), .busy(busy_le), .invalidate(invalidate),
    .mem_rd(mr_le), .mem_addr(ma_le), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .timeout(to_le), .overrun(ov_le), .state_dbg(dbg_le));

  unloader_mem_reader #(.ADDR_WIDTH(28), .BIG_ENDIAN_WORD(1'b1), .TIMEOUT_CYCLES(TMO)) u_be (
    .clk_memory(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_be), .read_valid(rv_be), .busy(busy_be), .invalidate(invalidate),
    .mem_rd(mr_be), .mem_addr(ma_be), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .timeout(to_be), .overrun(ov_be), .state_dbg(dbg_be));

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control flags: {read_valid, mem_rd, busy, timeout, overrun, state_dbg}.
  task automatic check_ctl(input string tag, input bit rv, input bit mr, input bit bz,
                           input bit to, input bit ov);
    check({tag, "_le"}, {26'd0, rv_le, mr_le, busy_le, to_le, ov_le, dbg_le}, {26'd0, rv, mr, bz, to, ov, bz});
    check({tag, "_be"}, {26'd0, rv_be, mr_be, busy_be, to_be, ov_be, dbg_be}, {26'd0, rv, mr, bz, to, ov, bz});
  endtask

  task automatic check_data(input string tag);
    check({tag, "_le"}, {24'd0, rd_le}, {24'd0, exp_le});
    check({tag, "_be"}, {24'd0, rd_be}, {24'd0, exp_be});
  endtask

  // One byte read issued from IDLE. ack_n: mem_rd cycle (1..TMO) carrying mem_ack, 0 = never.
  // ovr_c: mem_rd cycle in which a second read_en is thrown in, 0 = none.
  task automatic do_read(input logic [27:0] addr, input int ack_n, input logic [15:0] word,
                         input int ovr_c, input bit inv);
    bit hit;
    bit ov;
    hit = CACHE && m_valid && (m_tag == addr[27:1]) && !inv;
    if (inv) m_valid = 1'b0;
    read_en = 1'b1; read_addr = addr; invalidate = inv;
    @(negedge clk);
    read_en = 1'b0; invalidate = 1'b0;
    if (hit) begin
      exp_le = pick(m_word, addr[0]);
      exp_be = pick(m_word, ~addr[0]);
      check_ctl("hit_ctl", 1, 0, 0, 0, 0);
      check_data("hit_data");
    end else begin
      ov = 1'b0;
      for (int c = 1; c <= TMO; c++) begin
        check_ctl("req_ctl", 0, 1, 1, 0, ov);
        check("mem_addr_le", {5'd0, ma_le}, {5'd0, addr[27:1]});
        check("mem_addr_be", {5'd0, ma_be}, {5'd0, addr[27:1]});
        read_en = (c == ovr_c); read_addr = addr ^ 28'h5A;
        mem_ack = (c == ack_n);
        mem_rd_data = (c == ack_n) ? word : 16'($urandom);
        @(negedge clk);
        ov = (c == ovr_c);
        read_en = 1'b0; mem_ack = 1'b0;
        if (c == ack_n) break;
      end
      if (ack_n != 0) begin
        exp_le = pick(word, addr[0]);
        exp_be = pick(word, ~addr[0]);
        m_valid = 1'b1; m_tag = addr[27:1]; m_word = word;
      end else begin
        exp_le = 8'hFF;
        exp_be = 8'hFF;
      end
      check_ctl("done_ctl", 1, 0, 0, ack_n == 0, ov);
      check_data("done_data");
    end
    @(negedge clk);
    check_ctl("after_ctl", 0, 0, 0, 0, 0);
    check_data("held_data");
  endtask

  task automatic pulse_inv();
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    m_valid = 1'b0;
    check_ctl("inv_ctl", 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_ctl("rst_ctl", 0, 0, 0, 0, 0);
    check_data("rst_data");
    check("rst_mem_addr", {5'd0, ma_le}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_ctl("idle_ctl", 0, 0, 0, 0, 0);

    // Miss with ack on the 4th mem_rd cycle (ack and timeout coincide: ack wins)
    do_read(28'hC, 4, 16'hBBAA, 0, 0);
    // Same word: hit with cache, fresh fetch without
    do_read(28'hD, 2, 16'h1234, 0, 0);
    // Endianness pair
    do_read(28'h124, 1, 16'hDDCC, 0, 0);
    do_read(28'h125, 1, 16'hDDCC, 0, 0);
    // Timeout, then same word still misses
    do_read(28'h200, 0, 16'h0000, 0, 0);
    do_read(28'h200, 2, 16'h5566, 0, 0);
    // Overrun mid-request and in the ack cycle
    do_read(28'h300, 3, 16'h7788, 2, 0);
    do_read(28'h302, 2, 16'h99AB, 2, 0);
    // Invalidate pulse, then invalidate coincident with a lookup
    pulse_inv();
    do_read(28'h302, 1, 16'h1357, 0, 0);
    do_read(28'h303, 1, 16'h2468, 0, 1);
    // Address at top of range
    do_read(28'hFFFFFFF, 1, 16'hC0DE, 0, 0);

    // Randomized reads over a small address window to provoke hits
    for (int i = 0; i < 60; i++) begin
      int an, oc;
      logic [27:0] a;
      a  = 28'h0000040 + 28'($urandom_range(0, 7));
      an = $urandom_range(0, TMO);
      oc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (an == 0) ? TMO : an) : 0;
      if ($urandom_range(0, 9) == 0) pulse_inv();
      do_read(a, an, 16'($urandom), oc, $urandom_range(0, 7) == 0);
    end

    // Reset mid-request drops mem_rd at once; a stray ack afterwards is ignored
    read_en = 1'b1; read_addr = 28'h4001;
    @(negedge clk);
    read_en = 1'b0;
    check_ctl("pre_rst_ctl", 0, 1, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    exp_le = 8'h00; exp_be = 8'h00; m_valid = 1'b0;
    check_ctl("async_rst_ctl", 0, 0, 0, 0, 0);
    check_data("async_rst_data");
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rd_data = 16'hEEEE;
    @(negedge clk);
    mem_ack = 1'b0;
    check_ctl("stray_ack_ctl", 0, 0, 0, 0, 0);
    check_data("stray_ack_data");
    @(negedge clk);
    check_ctl("stray_ack_ctl2", 0, 0, 0, 0, 0);
    // After reset the cache is empty: a read of the last word misses
    do_read(28'h4001, 1, 16'hA5A5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
